// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_pkg;

  // Default data width; must match the FIFO it feeds.
  localparam int FIFO_WIDTH = 8;

  // Width of the free-running beat counter.
  localparam int WR_COUNT_W = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-facing bundle of the write arbiter.
// slave: the arbiter side. master: producers plus FIFO status (the bench).
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     full;
  logic                     overflow;
  logic [NUM_REQ-1:0]       gnt;
  logic                     wr_en;
  logic [WIDTH-1:0]         wdata;
  logic                     ovf_err;
  logic [WR_COUNT_W-1:0]    wr_count;

  modport slave (
    input  req, req_data, full, overflow,
    output gnt, wr_en, wdata, ovf_err, wr_count
  );

  modport master (
    output req, req_data, full, overflow,
    input  gnt, wr_en, wdata, ovf_err, wr_count
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
  // The sum is one bit wider so the modulo wrap works for any NUM_REQ.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    pick_o  = '0;
    valid_o = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ))
        sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock for the single FIFO write port.
// Grants are combinational (zero latency) from registered state and inputs;
// full gates the grant in the same cycle so wr_en never fires into a full FIFO.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             wr_clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST);
  localparam logic [PTR_W-1:0]  PTR_MAX    = PTR_W'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [BCNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  ovf_err_q;
  logic [WR_COUNT_W-1:0] wr_count_q;

  logic [NUM_REQ-1:0]    pick;
  logic                  pick_vld;
  logic [PTR_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  wr_en;
  logic [WIDTH-1:0]      wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .valid_o  (pick_vld)
  );

  // One-hot pick to index, used to record the new owner.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PTR_W'(i);
  end

  // Next-state and grant decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    gnt        = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (!bus.full && pick_vld) begin
          gnt     = pick;
          owner_d = pick_idx;
          if (MAX_BURST == 1) begin
            rr_ptr_d = ptr_inc(pick_idx);
          end else begin
            state_d    = ARB_BURST;
            beat_cnt_d = BCNT_W'(1);
          end
        end
      end
      ARB_BURST: begin
        if (bus.req[owner_q]) begin
          // Full only stalls: the owner keeps the port and its count.
          if (!bus.full) begin
            gnt[owner_q] = 1'b1;
            beat_cnt_d   = beat_cnt_q + 1'b1;
            if (beat_cnt_d == BURST_LAST) begin
              state_d  = ARB_IDLE;
              rr_ptr_d = ptr_inc(owner_q);
            end
          end
        end else begin
          // Owner let go: release with one bubble cycle.
          state_d  = ARB_IDLE;
          rr_ptr_d = ptr_inc(owner_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign wr_en = |gnt;

  // Data mux follows the one-hot grant; zero when idle.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) wdata = bus.req_data[i*WIDTH +: WIDTH];
  end

  // State, pointer, sticky error and beat counter.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      ovf_err_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_err_q  <= ovf_err_q | bus.overflow;
      wr_count_q <= wr_count_q + WR_COUNT_W'(wr_en);
    end
  end

  assign bus.gnt      = gnt;
  assign bus.wr_en    = wr_en;
  assign bus.wdata    = wdata;
  assign bus.ovf_err  = ovf_err_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (WIDTH=8, NUM_REQ=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus();

  fifo_wr_arbiter #(.WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .wr_clk (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic        ovf;
    logic [3:0]  gnt;
    logic        wen;
    logic [7:0]  wd;
    logic        eovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[$];
  int n_run  = 0;
  int n_fail = 0;

  localparam logic [31:0] D = 32'h4433_2211;

  function automatic vec_t V(logic r, logic [3:0] rq, logic [31:0] d, logic f, logic o,
                             logic [3:0] g, logic w, logic [7:0] wd, logic eo, logic [15:0] c);
    vec_t v;
    v.rst = r; v.req = rq; v.data = d; v.full = f; v.ovf = o;
    v.gnt = g; v.wen = w; v.wd = wd; v.eovf = eo; v.cnt = c;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [3:0] rq, logic [31:0] d, logic f, logic o);
    rst = r; bus.req = rq; bus.req_data = d; bus.full = f; bus.overflow = o;
  endtask

  // Compare all outputs at the falling edge, then advance one rising edge.
  task automatic check_cycle(string tag, logic [3:0] g, logic w, logic [7:0] wd,
                             logic eo, logic [15:0] c);
    @(negedge clk);
    chk({tag, " gnt"},      32'(bus.gnt),      32'(g));
    chk({tag, " wr_en"},    32'(bus.wr_en),    32'(w));
    chk({tag, " wdata"},    32'(bus.wdata),    32'(wd));
    chk({tag, " ovf_err"},  32'(bus.ovf_err),  32'(eo));
    chk({tag, " wr_count"}, 32'(bus.wr_count), 32'(c));
    @(posedge clk); #1;
  endtask

  initial begin
    // Single requester 2, data A0..A5: six back-to-back beats across a forced release.
    for (int k = 0; k < 6; k++)
      vt.push_back(V(0, 4'b0100, {8'h00, 8'(8'hA0 + k), 16'h0000}, 0, 0,
                     4'b0100, 1, 8'(8'hA0 + k), 0, 16'(k)));
    vt.push_back(V(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 16'd6));
    vt.push_back(V(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 16'd6));
    // All requesting: bursts of 4 in order 0,1,2,3.
    for (int k = 0; k < 16; k++)
      vt.push_back(V(0, 4'b1111, D, 0, 0, 4'(1 << (k / 4)), 1,
                     8'(8'h11 * (k / 4 + 1)), 0, 16'(k)));
    vt.push_back(V(0, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 0, 16'd16));
    vt.push_back(V(1, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 0, 16'd16));
    // Requester 1, full for 3 cycles after beat 2, then rr_ptr lands on 2.
    vt.push_back(V(0, 4'b0010, D, 0, 0, 4'b0010, 1, 8'h22, 0, 16'd0));
    vt.push_back(V(0, 4'b0010, D, 0, 0, 4'b0010, 1, 8'h22, 0, 16'd1));
    for (int k = 0; k < 3; k++)
      vt.push_back(V(0, 4'b0010, D, 1, 0, 4'b0000, 0, 8'h00, 0, 16'd2));
    vt.push_back(V(0, 4'b0010, D, 0, 0, 4'b0010, 1, 8'h22, 0, 16'd2));
    vt.push_back(V(0, 4'b0010, D, 0, 0, 4'b0010, 1, 8'h22, 0, 16'd3));
    vt.push_back(V(0, 4'b1111, D, 0, 0, 4'b0100, 1, 8'h33, 0, 16'd4));
    vt.push_back(V(1, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 0, 16'd5));
    // Full while idle blocks the first grant; overflow pulse goes sticky.
    vt.push_back(V(0, 4'b0001, D, 1, 0, 4'b0000, 0, 8'h00, 0, 16'd0));
    vt.push_back(V(0, 4'b0001, D, 0, 0, 4'b0001, 1, 8'h11, 0, 16'd0));
    vt.push_back(V(0, 4'b0001, D, 0, 1, 4'b0001, 1, 8'h11, 0, 16'd1));
    vt.push_back(V(0, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 1, 16'd2));
    vt.push_back(V(0, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 1, 16'd2));
    // Owner 3 drops after beat 1: one bubble, then pointer wraps to 0.
    vt.push_back(V(0, 4'b1000, D, 0, 0, 4'b1000, 1, 8'h44, 1, 16'd2));
    vt.push_back(V(0, 4'b0011, D, 0, 0, 4'b0000, 0, 8'h00, 1, 16'd3));
    vt.push_back(V(0, 4'b0011, D, 0, 0, 4'b0001, 1, 8'h11, 1, 16'd3));
    vt.push_back(V(1, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 1, 16'd4));
    vt.push_back(V(0, 4'b0000, D, 0, 0, 4'b0000, 0, 8'h00, 0, 16'd0));

    // Reset held two cycles, then check the idle outputs.
    drive(1, 4'b0000, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_cycle("reset", 4'b0000, 0, 8'h00, 0, 16'd0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].req, vt[i].data, vt[i].full, vt[i].ovf);
      check_cycle($sformatf("vec%0d", i), vt[i].gnt, vt[i].wen, vt[i].wd,
                  vt[i].eovf, vt[i].cnt);
    end

    // Non-owners rising mid-burst are ignored until the burst ends.
    drive(0, 4'b0001, D, 0, 0); check_cycle("lock0", 4'b0001, 1, 8'h11, 0, 16'd0);
    drive(0, 4'b0001, D, 0, 0); check_cycle("lock1", 4'b0001, 1, 8'h11, 0, 16'd1);
    drive(0, 4'b0111, D, 0, 0); check_cycle("lock2", 4'b0001, 1, 8'h11, 0, 16'd2);
    drive(0, 4'b0111, D, 0, 0); check_cycle("lock3", 4'b0001, 1, 8'h11, 0, 16'd3);
    drive(0, 4'b0111, D, 0, 0); check_cycle("lock4", 4'b0010, 1, 8'h22, 0, 16'd4);
    // Reset mid-burst: that cycle's beat is not counted, pointer back to 0.
    drive(1, 4'b0111, D, 0, 0); check_cycle("rstmid", 4'b0010, 1, 8'h22, 0, 16'd5);
    drive(0, 4'b0110, D, 0, 0); check_cycle("postrst", 4'b0010, 1, 8'h22, 0, 16'd0);
    drive(0, 4'b0000, D, 0, 0); check_cycle("drop", 4'b0000, 0, 8'h00, 0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
